// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and write-back grant encoding.
package cpu_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_A    = 2'd1,
      GNT_B    = 2'd2
   } wb_grant_t;

   // Even parity over a write-back address, usable by protected register-file wrappers.
   function automatic logic addr_parity(input logic [REG_ADDR_W-1:0] addr);
      return ^addr;
   endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard for destinations of outstanding long-latency operations.
// Tracks one busy bit per architectural register (x0 is never busy), answers
// the WAW issue check and the RAW hazard check for decode.
module wb_scoreboard
   import cpu_pkg::*;
#(
   parameter int ADDRESS_WIDTH = REG_ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     iss_valid,
   input  logic [ADDRESS_WIDTH-1:0] iss_rd,
   output logic                     iss_ready,
   input  logic                     clr_valid,
   input  logic [ADDRESS_WIDTH-1:0] clr_rd,
   input  logic [ADDRESS_WIDTH-1:0] rs1,
   input  logic [ADDRESS_WIDTH-1:0] rs2,
   output logic                     hazard
);

   localparam int NREG = 2 ** ADDRESS_WIDTH;

   logic [NREG-1:0] busy_r;
   logic [NREG-1:0] set_vec_s;
   logic [NREG-1:0] clr_vec_s;
   logic [NREG-1:0] busy_nxt_s;
   logic            iss_ready_s;

   // Issue is blocked while the destination still has a result in flight.
   always_comb begin
      iss_ready_s = ~busy_r[iss_rd];
      iss_ready   = iss_ready_s;
      hazard      = busy_r[rs1] | busy_r[rs2];
   end

   // Build set/clear masks; a same-cycle set on the cleared index must win.
   always_comb begin
      set_vec_s = {NREG{1'b0}};
      clr_vec_s = {NREG{1'b0}};
      if (iss_valid && iss_ready_s) begin
         set_vec_s[iss_rd] = 1'b1;
      end else begin
         set_vec_s = {NREG{1'b0}};
      end
      if (clr_valid) begin
         clr_vec_s[clr_rd] = 1'b1;
      end else begin
         clr_vec_s = {NREG{1'b0}};
      end
      busy_nxt_s    = (busy_r & ~clr_vec_s) | set_vec_s;
      busy_nxt_s[0] = 1'b0;
   end

   // Busy vector state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= {NREG{1'b0}};
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner. Arbitrates pipeline write-back (A) against a
// long-latency unit (B) with starvation protection for B, registers the single
// write port, and hosts the busy scoreboard that drives decode hazards.
module regfile_wb_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDRESS_WIDTH = REG_ADDR_W,
   parameter int DATA_WIDTH    = XLEN,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     a_valid,
   input  logic [ADDRESS_WIDTH-1:0] a_rd,
   input  logic [DATA_WIDTH-1:0]    a_data,
   output logic                     a_ready,
   input  logic                     b_valid,
   input  logic [ADDRESS_WIDTH-1:0] b_rd,
   input  logic [DATA_WIDTH-1:0]    b_data,
   output logic                     b_ready,
   input  logic                     iss_valid,
   input  logic [ADDRESS_WIDTH-1:0] iss_rd,
   output logic                     iss_ready,
   input  logic [ADDRESS_WIDTH-1:0] rs1,
   input  logic [ADDRESS_WIDTH-1:0] rs2,
   output logic                     hazard,
   output logic                     we3,
   output logic [ADDRESS_WIDTH-1:0] ad3,
   output logic [DATA_WIDTH-1:0]    wd3
);

   localparam int                CNT_W      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

   logic [CNT_W-1:0]         starve_cnt_r;
   logic                     force_b_s;
   logic                     a_ready_s;
   logic                     b_ready_s;
   logic                     b_xfer_s;
   wb_grant_t                grant_s;
   logic                     we3_r;
   logic [ADDRESS_WIDTH-1:0] ad3_r;
   logic [DATA_WIDTH-1:0]    wd3_r;

   // Grant: A has priority unless B has waited the full starvation window.
   always_comb begin
      force_b_s = b_valid && (starve_cnt_r == STARVE_MAX);
      if (force_b_s) begin
         a_ready_s = 1'b0;
         b_ready_s = 1'b1;
      end else begin
         a_ready_s = 1'b1;
         b_ready_s = b_valid && !a_valid;
      end
      b_xfer_s = b_valid && b_ready_s;
      if (b_xfer_s) begin
         grant_s = GNT_B;
      end else if (a_valid && a_ready_s) begin
         grant_s = GNT_A;
      end else begin
         grant_s = GNT_NONE;
      end
   end

   assign a_ready = a_ready_s;
   assign b_ready = b_ready_s;
   assign we3     = we3_r;
   assign ad3     = ad3_r;
   assign wd3     = wd3_r;

   // Count cycles B is held off; any B transfer or idle B restarts the window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else if (b_valid && !b_ready_s) begin
         if (starve_cnt_r != STARVE_MAX) begin
            starve_cnt_r <= starve_cnt_r + CNT_ONE;
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end else begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end
   end

   // Registered write port; x0 writes are accepted but never enable the file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we3_r <= 1'b0;
         ad3_r <= {ADDRESS_WIDTH{1'b0}};
         wd3_r <= {DATA_WIDTH{1'b0}};
      end else begin
         case (grant_s)
            GNT_A: begin
               we3_r <= (a_rd != {ADDRESS_WIDTH{1'b0}});
               ad3_r <= a_rd;
               wd3_r <= a_data;
            end
            GNT_B: begin
               we3_r <= (b_rd != {ADDRESS_WIDTH{1'b0}});
               ad3_r <= b_rd;
               wd3_r <= b_data;
            end
            default: begin
               we3_r <= 1'b0;
               ad3_r <= ad3_r;
               wd3_r <= wd3_r;
            end
         endcase
      end
   end

   wb_scoreboard #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .iss_ready (iss_ready),
      .clr_valid (b_xfer_s),
      .clr_rd    (b_rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .hazard    (hazard)
   );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (default parameters).
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, b_valid, iss_valid;
   logic [4:0]  a_rd, b_rd, iss_rd, rs1, rs2;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready, iss_ready, hazard, we3;
   logic [4:0]  ad3;
   logic [31:0] wd3;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .rs1(rs1), .rs2(rs2), .hazard(hazard),
      .we3(we3), .ad3(ad3), .wd3(wd3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
      b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0;
      iss_valid = 1'b0; iss_rd = 5'd0;
      rs1 = 5'd0; rs2 = 5'd0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      #1;
      // Reset values
      check("rst_we3", we3, 1'b0);
      check("rst_ad3", ad3, 5'd0);
      check("rst_wd3", wd3, 32'd0);
      check("rst_a_ready", a_ready, 1'b1);
      check("rst_b_ready", b_ready, 1'b0);
      check("rst_iss_ready", iss_ready, 1'b1);
      check("rst_hazard", hazard, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // A only write
      a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
      #1;
      check("a_only_ready", a_ready, 1'b1);
      tick();
      a_valid = 1'b0;
      #1;
      check("a_only_we3", we3, 1'b1);
      check("a_only_ad3", ad3, 5'd5);
      check("a_only_wd3", wd3, 32'hDEADBEEF);
      tick();
      check("idle_we3", we3, 1'b0);
      check("idle_ad3_hold", ad3, 5'd5);
      check("idle_wd3_hold", wd3, 32'hDEADBEEF);

      // A and B both valid: A wins 4 cycles, then B is forced through
      a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h0000_0A0A;
      b_valid = 1'b1; b_rd = 5'd2; b_data = 32'h0000_0B0B;
      for (int k = 1; k <= 4; k++) begin
         #1;
         check("starve_a_ready", a_ready, 1'b1);
         check("starve_b_ready", b_ready, 1'b0);
         tick();
         check("starve_a_we3", we3, 1'b1);
         check("starve_a_ad3", ad3, 5'd1);
         check("starve_cnt", dut.starve_cnt_r, k);
      end
      #1;
      check("force_a_ready", a_ready, 1'b0);
      check("force_b_ready", b_ready, 1'b1);
      tick();
      check("force_we3", we3, 1'b1);
      check("force_ad3", ad3, 5'd2);
      check("force_wd3", wd3, 32'h0000_0B0B);
      check("force_cnt_clr", dut.starve_cnt_r, 0);
      check("after_force_a_ready", a_ready, 1'b1);
      check("after_force_b_ready", b_ready, 1'b0);
      idle_inputs();
      tick();

      // Issue rd=7, RAW hazard, B clears it
      iss_valid = 1'b1; iss_rd = 5'd7;
      #1;
      check("iss7_ready", iss_ready, 1'b1);
      tick();
      iss_valid = 1'b0;
      rs1 = 5'd7; rs2 = 5'd0;
      #1;
      check("raw_hazard", hazard, 1'b1);
      check("waw_iss_ready", iss_ready, 1'b0);
      b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h0000_0077;
      #1;
      check("b7_ready", b_ready, 1'b1);
      check("no_bypass_hazard", hazard, 1'b1);
      tick();
      b_valid = 1'b0;
      #1;
      check("cleared_hazard", hazard, 1'b0);
      check("b7_we3", we3, 1'b1);
      check("b7_ad3", ad3, 5'd7);
      check("b7_wd3", wd3, 32'h0000_0077);

      // rs2 path
      iss_valid = 1'b1; iss_rd = 5'd9;
      tick();
      iss_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd9;
      #1;
      check("rs2_hazard", hazard, 1'b1);
      b_valid = 1'b1; b_rd = 5'd9;
      tick();
      b_valid = 1'b0;
      #1;
      check("rs2_cleared", hazard, 1'b0);

      // Same-cycle issue and B transfer to rd=7: set wins
      iss_valid = 1'b1; iss_rd = 5'd7;
      b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h0000_0707;
      rs1 = 5'd7; rs2 = 5'd0;
      #1;
      check("same_iss_ready", iss_ready, 1'b1);
      check("same_b_ready", b_ready, 1'b1);
      tick();
      b_valid = 1'b0;
      #1;
      check("same_busy7", dut.u_sb.busy_r[7], 1'b1);
      check("same_hazard", hazard, 1'b1);
      check("second_iss_ready", iss_ready, 1'b0);
      tick();
      iss_valid = 1'b0;
      b_valid = 1'b1; b_rd = 5'd7;
      tick();
      b_valid = 1'b0;
      #1;
      check("busy7_final_clear", hazard, 1'b0);

      // x0 writes and issues
      a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h0000_1234;
      #1;
      check("x0_a_ready", a_ready, 1'b1);
      tick();
      a_valid = 1'b0;
      #1;
      check("x0_we3", we3, 1'b0);
      iss_valid = 1'b1; iss_rd = 5'd0;
      #1;
      check("x0_iss_ready", iss_ready, 1'b1);
      tick();
      rs1 = 5'd0; rs2 = 5'd0;
      #1;
      check("x0_hazard", hazard, 1'b0);
      check("x0_iss_ready_again", iss_ready, 1'b1);
      check("x0_busy_vec", dut.u_sb.busy_r, 32'd0);
      iss_valid = 1'b0;

      // Asynchronous reset mid-stream with B waiting
      iss_valid = 1'b1; iss_rd = 5'd12;
      a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h0000_3333;
      b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h0000_4444;
      tick();
      iss_valid = 1'b0;
      tick();
      check("pre_rst_we3", we3, 1'b1);
      check("pre_rst_cnt", dut.starve_cnt_r, 2);
      check("pre_rst_busy12", dut.u_sb.busy_r[12], 1'b1);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_we3", we3, 1'b0);
      check("mid_rst_busy", dut.u_sb.busy_r, 32'd0);
      check("mid_rst_cnt", dut.starve_cnt_r, 0);
      check("mid_rst_a_ready", a_ready, 1'b1);
      check("mid_rst_b_ready", b_ready, 1'b0);
      idle_inputs();
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_we3", we3, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the bench can never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
